// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request handshake plus result handshake.
interface alu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;
    logic            busy;

    modport master (
        output in_valid, op, data1, data2, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, op, data1, data2, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, XLEN-cycle shift-add multiply and
// restoring divide, result held in a register until the consumer takes it.
module alu_seq #(
    parameter int unsigned XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [CW-1:0] LastCnt = CW'(XLEN - 1);

    localparam logic [7:0] OpAdd   = 8'h01;
    localparam logic [7:0] OpSub   = 8'h02;
    localparam logic [7:0] OpSll   = 8'h03;
    localparam logic [7:0] OpSlt   = 8'h04;
    localparam logic [7:0] OpSltu  = 8'h05;
    localparam logic [7:0] OpXor   = 8'h06;
    localparam logic [7:0] OpSrl   = 8'h07;
    localparam logic [7:0] OpSra   = 8'h08;
    localparam logic [7:0] OpOr    = 8'h09;
    localparam logic [7:0] OpAnd   = 8'h0a;
    localparam logic [7:0] OpMul   = 8'h0b;
    localparam logic [7:0] OpMulh  = 8'h0c;
    localparam logic [7:0] OpMulhu = 8'h0d;
    localparam logic [7:0] OpDiv   = 8'h0e;
    localparam logic [7:0] OpDivu  = 8'h0f;
    localparam logic [7:0] OpRem   = 8'h10;
    localparam logic [7:0] OpRemu  = 8'h11;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res;
    logic [7:0]      op_q;
    logic [XLEN-1:0] hi;    // product high half / partial remainder
    logic [XLEN-1:0] lo;    // multiplier shifting out / dividend becoming quotient
    logic [XLEN-1:0] opnd;  // multiplicand / divisor magnitude
    logic            neg_q;
    logic            neg_r;
    logic            dz;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? -x : x;
    endfunction

    assign bus.in_ready  = (state == StIdle);
    assign bus.busy      = (state == StMul) || (state == StDiv);
    assign bus.out_valid = (state == StDone);
    assign bus.res       = res;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    assign shamt = bus.data2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OpAdd:   alu_res = bus.data1 + bus.data2;
            OpSub:   alu_res = bus.data1 - bus.data2;
            OpSll:   alu_res = bus.data1 << shamt;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.data1) < $signed(bus.data2)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, bus.data1 < bus.data2};
            OpXor:   alu_res = bus.data1 ^ bus.data2;
            OpSrl:   alu_res = bus.data1 >> shamt;
            OpSra:   alu_res = XLEN'($signed(bus.data1) >>> shamt);
            OpOr:    alu_res = bus.data1 | bus.data2;
            OpAnd:   alu_res = bus.data1 & bus.data2;
            default: alu_res = '0;
        endcase
    end

    logic is_mul, is_div, sgn_mul, sgn_div;
    assign is_mul  = (bus.op >= OpMul) && (bus.op <= OpMulhu);
    assign is_div  = (bus.op >= OpDiv) && (bus.op <= OpRemu);
    assign sgn_mul = (bus.op == OpMulh);
    assign sgn_div = (bus.op == OpDiv) || (bus.op == OpRem);

    // One iteration of each engine plus the sign-corrected result of the final step.
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo;
    logic [XLEN:0]     shifted, diff;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   mul_fin, div_fin, quot, remv;

    always_comb begin
        mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], lo[XLEN-1:1]};
        prod_c  = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
        mul_fin = (op_q == OpMul) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];

        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (diff[XLEN]) begin
            div_hi = shifted[XLEN-1:0];
            div_lo = {lo[XLEN-2:0], 1'b0};
        end else begin
            div_hi = diff[XLEN-1:0];
            div_lo = {lo[XLEN-2:0], 1'b1};
        end
        quot    = dz ? '1 : (neg_q ? -div_lo : div_lo);
        remv    = neg_r ? -div_hi : div_hi;
        div_fin = ((op_q == OpDiv) || (op_q == OpDivu)) ? quot : remv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            cnt   <= '0;
            res   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        op_q <= bus.op;
                        cnt  <= '0;
                        hi   <= '0;
                        if (is_mul) begin
                            lo    <= sgn_mul ? mag(bus.data2) : bus.data2;
                            opnd  <= sgn_mul ? mag(bus.data1) : bus.data1;
                            neg_q <= sgn_mul && (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]);
                            state <= StMul;
                        end else if (is_div) begin
                            lo    <= sgn_div ? mag(bus.data1) : bus.data1;
                            opnd  <= sgn_div ? mag(bus.data2) : bus.data2;
                            neg_q <= sgn_div && (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]);
                            neg_r <= sgn_div && bus.data1[XLEN-1];
                            dz    <= (bus.data2 == '0);
                            state <= StDiv;
                        end else begin
                            res   <= alu_res;
                            state <= StDone;
                        end
                    end
                end
                StMul: begin
                    hi  <= mul_hi;
                    lo  <= mul_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        res   <= mul_fin;
                        state <= StDone;
                    end
                end
                StDiv: begin
                    hi  <= div_hi;
                    lo  <= div_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        res   <= div_fin;
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
